// File: rtl/intpol2_pkg.sv
// Shared constants and FSM state encoding for the interpolator output reader.
package intpol2_pkg;

    localparam int DEF_DW    = 32;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/intpol2_skid_buf.sv
// Two-entry FIFO-ordered buffer absorbing the one-cycle read latency of the output FIFO.
module intpol2_skid_buf
    import intpol2_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic [1:0]    occ
);

    logic [DW-1:0] head_q;
    logic [DW-1:0] tail_q;
    logic          pop_ok;

    assign pop_ok = pop & (occ != 2'd0);
    assign dout   = head_q;

    // head_q is always the oldest entry; tail_q only matters when occ is 2.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q <= '0;
            tail_q <= '0;
            occ    <= 2'd0;
        end else if (clear) begin
            occ <= 2'd0;
        end else begin
            case ({push, pop_ok})
                2'b10: begin
                    if (occ == 2'd0) begin
                        head_q <= din;
                    end else begin
                        tail_q <= din;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    occ    <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        head_q <= din;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= din;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/intpol2_out_reader.sv
// Drains the interpolator output FIFO into a valid/ready stream.
// Define INTPOL2_TLAST_EN to build the frame counter, m_tlast and frame_done.
module intpol2_out_reader
    import intpol2_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear,
    input  logic             en,
    input  logic             fifo_empty,
    input  logic [DW-1:0]    fifo_rdata,
    output logic             fifo_rd_en,
    input  logic [CNT_W-1:0] frame_len,
    output logic [DW-1:0]    m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tlast,
    output logic             busy,
    output logic             frame_done,
    output logic [CNT_W-1:0] beat_cnt
);

    state_t     state;
    state_t     state_nx;
    logic       inflight;
    logic [1:0] occ;
    logic       hs;
    logic       push;
    logic [2:0] committed;

    intpol2_skid_buf #(.DW(DW)) u_buf (
        .clk   (clk),
        .rstn  (rstn),
        .clear (clear),
        .push  (push),
        .pop   (hs),
        .din   (fifo_rdata),
        .dout  (m_tdata),
        .occ   (occ)
    );

    assign m_tvalid = (occ != 2'd0);
    assign hs       = m_tvalid & m_tready;
    assign push     = inflight & ~clear;
    assign busy     = (state != IDLE);

    // The head beat leaving this cycle frees its slot for the read issued now,
    // which keeps one beat per cycle while never letting occ exceed 2.
    assign committed  = 3'(occ) + 3'(inflight) - 3'(hs);
    assign fifo_rd_en = (state == RUN) & en & ~fifo_empty & ~clear & (committed < 3'd2);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (en) state_nx = RUN;
            RUN:     if (!en) state_nx = DRAIN;
            DRAIN: begin
                if (en) begin
                    state_nx = RUN;
                end else if ((occ == 2'd0) && !inflight) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (clear) begin
            state_nx = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            inflight <= 1'b0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nx;
            inflight <= fifo_rd_en;
            if (clear) begin
                beat_cnt <= '0;
            end else if (hs) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
        end
    end

`ifdef INTPOL2_TLAST_EN
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] len_m1;

    // A latched length of 0 wraps to all-ones here, giving 2^CNT_W beats per frame.
    assign len_m1  = len_q - ONE;
    assign m_tlast = m_tvalid & (frame_cnt == len_m1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            len_q      <= '0;
            frame_cnt  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= hs & m_tlast & ~clear;
            if (clear) begin
                frame_cnt <= '0;
            end else if (hs) begin
                frame_cnt <= m_tlast ? '0 : frame_cnt + ONE;
            end
            if ((state == IDLE) && en && !clear) begin
                len_q <= frame_len;
            end
        end
    end
`else
    logic unused_frame_len;

    assign unused_frame_len = ^frame_len;
    assign m_tlast          = 1'b0;
    assign frame_done       = 1'b0;
`endif

endmodule

// File: tb/tb_intpol2_out_reader.sv
// Directed bench for intpol2_out_reader: streaming, back-pressure, drain, clear and reset.
module tb_intpol2_out_reader;

    localparam int DW    = 32;
    localparam int CNT_W = 16;
`ifdef INTPOL2_TLAST_EN
    localparam bit TLAST = 1'b1;
`else
    localparam bit TLAST = 1'b0;
`endif

    logic             clk        = 1'b0;
    logic             rstn       = 1'b0;
    logic             clear      = 1'b0;
    logic             en         = 1'b0;
    logic             m_tready   = 1'b0;
    logic [CNT_W-1:0] frame_len  = 16'd4;
    logic [DW-1:0]    fifo_rdata = '0;
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic [DW-1:0]    m_tdata;
    logic             m_tvalid;
    logic             m_tlast;
    logic             busy;
    logic             frame_done;
    logic [CNT_W-1:0] beat_cnt;

    int checks   = 0;
    int failures = 0;

    intpol2_out_reader #(.DW(DW), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .clear      (clear),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_rd_en (fifo_rd_en),
        .frame_len  (frame_len),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tlast    (m_tlast),
        .busy       (busy),
        .frame_done (frame_done),
        .beat_cnt   (beat_cnt)
    );

    always #5 clk = ~clk;

    // Output FIFO model with one-cycle read latency
    logic [DW-1:0] fifo_mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en && (wr_ptr != rd_ptr)) begin
            fifo_rdata <= fifo_mem[rd_ptr[7:0]];
            rd_ptr     <= rd_ptr + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Monitor: logs handshakes and checks stall stability, occupancy and frame_done
    logic [DW-1:0] rx_data [$];
    logic          rx_last [$];
    int            rx_cyc  [$];
    logic [DW-1:0] exp_q   [$];
    int            cyc      = 0;
    int            first_rd = -1;
    int            first_hs = -1;
    int            fpos     = 0;
    logic          prev_stall   = 1'b0;
    logic          prev_last_hs = 1'b0;
    logic [DW-1:0] prev_data    = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rstn) begin
            if (prev_stall) begin
                checkOutput("stall_valid", 32'(m_tvalid), 32'd1);
                checkOutput("stall_data", m_tdata, prev_data);
            end
            checkOutput("occ_max", 32'(dut.occ > 2'd2), 32'd0);
            checkOutput("frame_done", 32'(frame_done), 32'(prev_last_hs));
            if (fifo_rd_en && first_rd < 0) first_rd = cyc;
            if (m_tvalid && m_tready) begin
                rx_data.push_back(m_tdata);
                rx_last.push_back(m_tlast);
                rx_cyc.push_back(cyc);
                if (first_hs < 0) first_hs = cyc;
            end
        end
        prev_stall   = rstn && !clear && m_tvalid && !m_tready;
        prev_last_hs = rstn && !clear && m_tvalid && m_tready && m_tlast;
        prev_data    = m_tdata;
    end

    task automatic applyStimulus(input logic e, input logic r, input logic c);
        @(posedge clk);
        #1;
        en       = e;
        m_tready = r;
        clear    = c;
    endtask

    task automatic loadFifo(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            fifo_mem[wr_ptr[7:0]] = DW'(base + i);
            exp_q.push_back(DW'(base + i));
            wr_ptr++;
        end
    endtask

    task automatic checkBeat(input string tag, input bit b2b, input int idx, inout int pc);
        logic [DW-1:0] d;
        logic          l;
        int            c;
        d = rx_data.pop_front();
        l = rx_last.pop_front();
        c = rx_cyc.pop_front();
        checkOutput({tag, "_data"}, d, exp_q.pop_front());
        checkOutput({tag, "_last"}, 32'(l), 32'(TLAST && (fpos == 3)));
        fpos = (fpos + 1) % 4;
        if (b2b && idx > 0) checkOutput({tag, "_gap"}, c - pc, 32'd1);
        pc = c;
    endtask

    task automatic drainCheck(input int n, input bit b2b, input string tag);
        int waited = 0;
        int pc = 0;
        while (rx_data.size() < n && waited < 80) begin
            @(posedge clk);
            waited++;
        end
        if (rx_data.size() < n) begin
            checkOutput({tag, "_timeout"}, rx_data.size(), n);
            return;
        end
        for (int i = 0; i < n; i++) checkBeat(tag, b2b, i, pc);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_tvalid"}, 32'(m_tvalid), 32'd0);
        checkOutput({tag, "_tdata"}, m_tdata, 32'd0);
        checkOutput({tag, "_tlast"}, 32'(m_tlast), 32'd0);
        checkOutput({tag, "_rd_en"}, 32'(fifo_rd_en), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        checkOutput({tag, "_beat_cnt"}, 32'(beat_cnt), 32'd0);
    endtask

    initial begin
        int pc;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkIdleOutputs("reset");
        @(posedge clk);
        #1 rstn = 1'b1;

        // Back-to-back stream of 0..9
        loadFifo(0, 10);
        applyStimulus(1'b1, 1'b1, 1'b0);
        drainCheck(10, 1'b1, "stream");
        checkOutput("first_latency", first_hs - first_rd, 32'd2);
        @(negedge clk);
        checkOutput("stream_beat_cnt", 32'(beat_cnt), 32'd10);
        checkOutput("stream_busy", 32'(busy), 32'd1);

        // Drop en with one word buffered and one in flight, then drain under stall
        applyStimulus(1'b1, 1'b0, 1'b0);
        loadFifo(20, 5);
        @(posedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("drain_busy", 32'(busy), 32'd1);
        checkOutput("drain_tvalid", 32'(m_tvalid), 32'd1);
        checkOutput("drain_head", m_tdata, 32'd20);
        checkOutput("drain_rd_en", 32'(fifo_rd_en), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        drainCheck(2, 1'b1, "drain");
        repeat (3) @(negedge clk);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_rd_en", 32'(fifo_rd_en), 32'd0);
        checkOutput("idle_beat_cnt", 32'(beat_cnt), 32'd12);
        checkOutput("idle_no_extra", rx_data.size(), 32'd0);

        // Clear with one word buffered and one read in flight
        loadFifo(25, 3);
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        applyStimulus(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("pre_clear_head", m_tdata, 32'd22);
        applyStimulus(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("clear_tvalid", 32'(m_tvalid), 32'd0);
        checkOutput("clear_beat_cnt", 32'(beat_cnt), 32'd0);
        checkOutput("clear_busy", 32'(busy), 32'd0);
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        fpos = 0;
        applyStimulus(1'b1, 1'b1, 1'b0);
        drainCheck(4, 1'b1, "after_clear");
        @(negedge clk);
        checkOutput("after_clear_beat_cnt", 32'(beat_cnt), 32'd4);

        // Framed stream of 12 beats
        loadFifo(100, 12);
        drainCheck(12, 1'b1, "frame");
        @(negedge clk);
        checkOutput("frame_beat_cnt", 32'(beat_cnt), 32'd16);

        // Back-pressure with ready pattern 1,0,0,1
        loadFifo(200, 8);
        for (int i = 0; i < 24; i++) begin
            applyStimulus(1'b1, ((i % 4) == 0) || ((i % 4) == 3), 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 1'b0);
        drainCheck(8, 1'b0, "stall");
        @(negedge clk);
        checkOutput("stall_beat_cnt", 32'(beat_cnt), 32'd24);

        // Asynchronous reset in the middle of a stream
        loadFifo(300, 10);
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        checkIdleOutputs("midrst");
        en = 1'b0;
        pc = 0;
        while (rx_data.size() > 0) checkBeat("pre_rst", 1'b0, 0, pc);
        exp_q.delete();
        for (int p = rd_ptr; p < wr_ptr; p++) exp_q.push_back(fifo_mem[p[7:0]]);
        fpos = 0;
        @(posedge clk);
        #1 rstn = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0);
        drainCheck(exp_q.size(), 1'b1, "after_rst");
        repeat (3) @(negedge clk);
        checkOutput("final_no_extra", rx_data.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog");
    end

endmodule
